// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard/stall sequencer.
// Imported by the top FSM and the mul/div busy counter.
package hazard_pkg;

  localparam int REG_W_DEFAULT      = 5;
  localparam int MD_LATENCY_DEFAULT = 32;

  localparam logic [REG_W_DEFAULT-1:0] ZERO_REG = 5'd0;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    BR2 = 1'b1
  } hz_state_e;

endpackage

// File: rtl/md_busy_counter.sv
// Tracks the in-flight mult/div: the busy flag stays high for MD_LATENCY cycles
// after a start pulse; a new start always reloads the full latency.
module md_busy_counter import hazard_pkg::*; #(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int MD_CNT_W   = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start,
  output logic md_busy
);

  localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(MD_LATENCY - 1);

  logic [MD_CNT_W-1:0] md_cnt_r;
  logic                md_busy_r;

  // Load on start, count down while busy, drop busy after the zero count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_r  <= {MD_CNT_W{1'b0}};
      md_busy_r <= 1'b0;
    end else if (md_start) begin
      md_cnt_r  <= LOAD_VAL;
      md_busy_r <= 1'b1;
    end else if (md_busy_r) begin
      if (md_cnt_r != {MD_CNT_W{1'b0}}) begin
        md_cnt_r <= md_cnt_r - MD_CNT_W'(1);
      end else begin
        md_busy_r <= 1'b0;
      end
    end
  end

  assign md_busy = md_busy_r;

endmodule

// File: rtl/hazard_stall_sequencer.sv
// ID-stage stall controller: load-use, branch-operand and HI/LO hazards drive
// PC/IFID enables, the ID/EX bubble and the taken-branch IF/ID flush.
module hazard_stall_sequencer import hazard_pkg::*; #(
  parameter int REG_W      = REG_W_DEFAULT,
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int MD_CNT_W   = 6,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  IFIDRegRs,
  input  logic [REG_W-1:0]  IFIDRegRt,
  input  logic [REG_W-1:0]  IDEXRegRt,
  input  logic [REG_W-1:0]  IDEXRegDST,
  input  logic              IDEXRegWrite,
  input  logic              IDEXMemRead,
  input  logic              Branch,
  input  logic              BranchTaken,
  input  logic              IDMdUse,
  input  logic              md_start,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              Stall,
  output logic              IFIDFlush,
  output logic              md_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [REG_W-1:0] ZERO_R = REG_W'(ZERO_REG);

  hz_state_e         state_r, state_nxt_s;
  logic              lu_s, bd_s, md_s, stall_req_s;
  logic              md_busy_s;
  logic [PERF_W-1:0] stall_cycles_r;

  md_busy_counter #(
    .MD_LATENCY (MD_LATENCY),
    .MD_CNT_W   (MD_CNT_W)
  ) u_md_busy_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_start (md_start),
    .md_busy  (md_busy_s)
  );

  // $zero is hardwired, so a zero destination never matches.
  assign lu_s = IDEXMemRead & (IDEXRegRt != ZERO_R) &
                ((IDEXRegRt == IFIDRegRs) | (IDEXRegRt == IFIDRegRt));
  assign bd_s = Branch & IDEXRegWrite & ~IDEXMemRead & (IDEXRegDST != ZERO_R) &
                ((IDEXRegDST == IFIDRegRs) | (IDEXRegDST == IFIDRegRt));
  assign md_s = md_busy_s & IDMdUse;

  // Stall FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and stall request; a load feeding a branch costs a second bubble.
  always_comb begin
    state_nxt_s = RUN;
    stall_req_s = 1'b0;
    case (state_r)
      RUN: begin
        stall_req_s = lu_s | bd_s | md_s;
        if (lu_s & Branch) begin
          state_nxt_s = BR2;
        end else begin
          state_nxt_s = RUN;
        end
      end
      BR2: begin
        stall_req_s = 1'b1;
        state_nxt_s = RUN;
      end
      default: begin
        stall_req_s = 1'b1;
        state_nxt_s = RUN;
      end
    endcase
  end

  // Pipeline controls; held in the safe stalled pattern while reset is low.
  always_comb begin
    PCWrite   = 1'b0;
    IFIDWrite = 1'b0;
    Stall     = 1'b1;
    IFIDFlush = 1'b0;
    if (rst_n) begin
      PCWrite   = ~stall_req_s;
      IFIDWrite = ~stall_req_s;
      Stall     = stall_req_s;
      IFIDFlush = Branch & BranchTaken & ~stall_req_s;
    end else begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      Stall     = 1'b1;
      IFIDFlush = 1'b0;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_r <= {PERF_W{1'b0}};
    end else if (stall_req_s && (stall_cycles_r != {PERF_W{1'b1}})) begin
      stall_cycles_r <= stall_cycles_r + PERF_W'(1);
    end
  end

  assign md_busy      = md_busy_s;
  assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_hazard_stall_sequencer.sv
// Scoreboard bench for hazard_stall_sequencer: directed scenarios plus random
// traffic, checked against a cycle-level reference model.
module tb_hazard_stall_sequencer;

  localparam int REG_W      = 5;
  localparam int MD_LATENCY = 4;
  localparam int MD_CNT_W   = 3;
  localparam int PERF_W     = 4;
  localparam int PERF_MAX   = (1 << PERF_W) - 1;

  typedef struct {
    int rs, rt, ex_rt, ex_dst;
    bit regwrite, memread, branch, taken, mduse, mdstart, rst;
  } stim_t;

  typedef struct {
    bit pcw, ifw, stall, flush, busy;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [REG_W-1:0] IFIDRegRs, IFIDRegRt, IDEXRegRt, IDEXRegDST;
  logic IDEXRegWrite, IDEXMemRead, Branch, BranchTaken, IDMdUse, md_start;
  logic PCWrite, IFIDWrite, Stall, IFIDFlush, md_busy;
  logic [PERF_W-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  // reference model state
  int m_md_rem = 0;
  int m_extra = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  hazard_stall_sequencer #(
    .REG_W(REG_W), .MD_LATENCY(MD_LATENCY), .MD_CNT_W(MD_CNT_W), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .IFIDRegRs(IFIDRegRs), .IFIDRegRt(IFIDRegRt),
    .IDEXRegRt(IDEXRegRt), .IDEXRegDST(IDEXRegDST),
    .IDEXRegWrite(IDEXRegWrite), .IDEXMemRead(IDEXMemRead),
    .Branch(Branch), .BranchTaken(BranchTaken),
    .IDMdUse(IDMdUse), .md_start(md_start),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .Stall(Stall),
    .IFIDFlush(IFIDFlush), .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle, compared half a cycle after drive.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("PCWrite", int'(PCWrite), int'(e.pcw));
      check("IFIDWrite", int'(IFIDWrite), int'(e.ifw));
      check("Stall", int'(Stall), int'(e.stall));
      check("IFIDFlush", int'(IFIDFlush), int'(e.flush));
      check("md_busy", int'(md_busy), int'(e.busy));
      check("stall_cycles", int'(stall_cycles), e.cnt);
    end
  end

  function automatic stim_t nop();
    stim_t s;
    s = '{rs: 0, rt: 0, ex_rt: 0, ex_dst: 0, regwrite: 1'b0, memread: 1'b0,
          branch: 1'b0, taken: 1'b0, mduse: 1'b0, mdstart: 1'b0, rst: 1'b0};
    return s;
  endfunction

  // Drive one cycle, predict its outputs, then advance the model over the edge.
  task automatic step(input stim_t s);
    exp_t e;
    bit lu, bd, md;
    rst_n        = ~s.rst;
    IFIDRegRs    = REG_W'(s.rs);
    IFIDRegRt    = REG_W'(s.rt);
    IDEXRegRt    = REG_W'(s.ex_rt);
    IDEXRegDST   = REG_W'(s.ex_dst);
    IDEXRegWrite = s.regwrite;
    IDEXMemRead  = s.memread;
    Branch       = s.branch;
    BranchTaken  = s.taken;
    IDMdUse      = s.mduse;
    md_start     = s.mdstart;
    if (s.rst) begin
      m_md_rem = 0; m_extra = 0; m_cnt = 0;
      e = '{pcw: 1'b0, ifw: 1'b0, stall: 1'b1, flush: 1'b0, busy: 1'b0, cnt: 0};
    end else begin
      lu = s.memread && s.ex_rt != 0 && (s.ex_rt == s.rs || s.ex_rt == s.rt);
      bd = s.branch && s.regwrite && !s.memread && s.ex_dst != 0 &&
           (s.ex_dst == s.rs || s.ex_dst == s.rt);
      md = (m_md_rem > 0) && s.mduse;
      e.stall = (m_extra > 0) || lu || bd || md;
      e.pcw   = !e.stall;
      e.ifw   = !e.stall;
      e.flush = s.branch && s.taken && !e.stall;
      e.busy  = m_md_rem > 0;
      e.cnt   = m_cnt;
    end
    sb_q.push_back(e);
    @(posedge clk);
    if (!s.rst) begin
      if (e.stall && m_cnt < PERF_MAX) m_cnt++;
      m_extra  = (m_extra > 0) ? 0 : ((lu && s.branch) ? 1 : 0);
      m_md_rem = s.mdstart ? MD_LATENCY : ((m_md_rem > 0) ? m_md_rem - 1 : 0);
    end
    #1;
  endtask

  initial begin
    stim_t s;
    rst_n = 1'b0;
    IFIDRegRs = '0; IFIDRegRt = '0; IDEXRegRt = '0; IDEXRegDST = '0;
    IDEXRegWrite = 1'b0; IDEXMemRead = 1'b0; Branch = 1'b0; BranchTaken = 1'b0;
    IDMdUse = 1'b0; md_start = 1'b0;
    @(posedge clk); #1;

    s = nop(); s.rst = 1'b1;
    repeat (2) step(s);

    // load-use then bubble
    s = nop(); s.memread = 1'b1; s.ex_rt = 8; s.rs = 8;
    step(s);
    s = nop(); s.rs = 8;
    step(s);

    // load feeding a branch: two bubbles, then taken branch flushes
    s = nop(); s.memread = 1'b1; s.ex_rt = 9; s.rt = 9; s.branch = 1'b1; s.taken = 1'b1;
    step(s);
    s = nop(); s.rt = 9; s.branch = 1'b1; s.taken = 1'b1;
    step(s);
    step(s);

    // ALU result feeding a branch, then the $zero destination case
    s = nop(); s.regwrite = 1'b1; s.ex_dst = 10; s.rs = 10; s.branch = 1'b1;
    step(s);
    s.ex_dst = 0; s.rs = 0;
    step(s);

    // mul/div with HI/LO use held, then without use
    s = nop(); s.mdstart = 1'b1;
    step(s);
    s = nop(); s.mduse = 1'b1;
    repeat (5) step(s);
    s = nop(); s.mdstart = 1'b1;
    step(s);
    s = nop();
    repeat (5) step(s);

    // reload on the final busy cycle keeps busy high
    s = nop(); s.mdstart = 1'b1;
    step(s);
    s = nop();
    repeat (MD_LATENCY - 1) step(s);
    s.mdstart = 1'b1;
    step(s);
    s = nop(); s.mduse = 1'b1;
    repeat (MD_LATENCY + 1) step(s);

    // reset while in BR2 with mul/div busy
    s = nop(); s.mdstart = 1'b1;
    step(s);
    s = nop(); s.memread = 1'b1; s.ex_rt = 3; s.rs = 3; s.branch = 1'b1;
    step(s);
    s = nop(); s.rst = 1'b1; s.mduse = 1'b1;
    step(s);
    s = nop(); s.mduse = 1'b1; s.branch = 1'b1; s.taken = 1'b1;
    step(s);

    // saturation of the stall counter
    s = nop(); s.memread = 1'b1; s.ex_rt = 5; s.rt = 5;
    repeat (20) step(s);

    // random traffic over a small register range to provoke matches
    s = nop(); s.rst = 1'b1;
    step(s);
    for (int i = 0; i < 400; i++) begin
      s.rs       = int'($urandom_range(0, 3));
      s.rt       = int'($urandom_range(0, 3));
      s.ex_rt    = int'($urandom_range(0, 3));
      s.ex_dst   = int'($urandom_range(0, 3));
      s.regwrite = 1'($urandom_range(0, 1));
      s.memread  = ($urandom_range(0, 3) == 0);
      s.branch   = ($urandom_range(0, 2) == 0);
      s.taken    = 1'($urandom_range(0, 1));
      s.mduse    = 1'($urandom_range(0, 1));
      s.mdstart  = ($urandom_range(0, 9) == 0);
      s.rst      = ($urandom_range(0, 49) == 0);
      step(s);
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
